pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline boundary register, the generic successor to the per-stage EX/MEM-style latches. It captures an opaque payload from stage N into stage N+1 under the global stall vector and inserts a NOP bubble when stage N stalls while N+1 runs. It adds an exception flush, a valid bit and a loop-back side channel that preserves multi-cycle ALU state (HI/LO accumulators, iteration counters) across stalls. It also adds bubble and hold counters for performance monitoring. One instance sits between each adjacent pair of stages (IF/ID … MEM/WB).

## Interface

Parameters:
- PAYLOAD_W, 128, width of the concatenated stage payload; the all-zero value is the NOP encoding.
- SIDE_W, 66, width of the loop-back side channel, e.g. {hilo[63:0], cnt[1:0]}.
- STALL_W, 6, width of the global stall vector.
- STAGE, 3, index of this boundary's upstream stage in the stall vector; legal range 0..STALL_W-1.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  global stall vector from the controller; 1 = Stop.
- flush  in  1  exception/redirect flush; kills the held entry.
- in_valid  in  1  upstream entry is a real instruction.
- in_payload  in  PAYLOAD_W  upstream stage results.
- side_i  in  SIDE_W  multi-cycle state produced by the upstream stage this cycle.
- out_valid  out  1  registered valid presented to the downstream stage.
- out_payload  out  PAYLOAD_W  registered payload.
- side_o  out  SIDE_W  registered side state, fed back to the upstream stage.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted since reset.
- hold_cycles  out  CNT_W  saturating count of consecutive hold cycles of the current entry.

## Operation

- Derived signals:
  - up_stop = stall[STAGE].
  - dn_stop = stall[STAGE+1] when STAGE < STALL_W-1; otherwise dn_stop = 0.
- Per-edge action, in strict priority order:
  1. **RESET** (rst=1):
     - out_valid=0, out_payload=0, side_o=0.
     - bubble_cnt=0, hold_cycles=0.
  2. **FLUSH** (flush=1):
     - out_valid=0, out_payload=0, side_o=0, hold_cycles=0.
     - bubble_cnt unchanged.
  3. **BUBBLE** (up_stop=1, dn_stop=0):
     - out_valid=0, out_payload=0.
     - side_o<=side_i, so multi-cycle state survives.
     - bubble_cnt+1 (saturating); hold_cycles=0.
  4. **ADVANCE** (up_stop=0):
     - out_valid<=in_valid, out_payload<=in_payload.
     - side_o<=0.
     - hold_cycles=0.
  5. **HOLD** (up_stop=1, dn_stop=1):
     - out_valid and out_payload unchanged.
     - side_o<=side_i.
     - hold_cycles+1 (saturating).
- State view, 2 bits derived from registers:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1, hold_cycles=0.
  - HELD: out_valid=1, hold_cycles>0.
- State transitions:
  - EMPTY→FULL on ADVANCE with in_valid=1.
  - FULL→HELD on HOLD.
  - HELD→FULL on ADVANCE with in_valid=1.
  - Any state→EMPTY on FLUSH, BUBBLE, or ADVANCE with in_valid=0.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- in_payload is captured even when in_valid=0; downstream qualifies on out_valid.

## Timing

- Latency: 1 cycle from in_* to out_* on ADVANCE. There is no combinational path from any input to any output.
- side_o reflects side_i one cycle later in BUBBLE and HOLD. The upstream stage must read side_o in the cycle after it stalls.
- flush in the same cycle as any stall pattern: flush wins. The entry is killed and side state is cleared.
- rst mid-stall or mid-multi-cycle operation: all outputs and counters return to zero on that edge. No state is retained.
- up_stop=0 with dn_stop=1 is a controller error. The block performs ADVANCE regardless; verification flags this pattern with an assertion.

## Structure

- Shared package `pipe_pkg`:
  - STALL_W and the Stop/NoStop constants.
  - The per-boundary payload field widths and a packed payload type per boundary, whose zero value equals the NOP encoding (NOP register address, write-disable, EXE_NOP_OP all zero).
  - The SIDE_W of each boundary.
- A single sub-module, `sat_counter` (CNT_W, inc, clr), is instantiated twice, for bubble_cnt and hold_cycles.
- Per-boundary top-level wrappers pack and unpack the named fields into out_payload.

## Test plan

- **Reset:** hold rst=1 for 2 cycles with in_payload=all-ones and in_valid=1 → all outputs 0. Release rst with stall=0 → next edge out_payload=all-ones, out_valid=1.
- **Bubble with side preservation:** stall=6'b001111 (STAGE=3 stop, stage 4 run), side_i=66'h2_DEAD_BEEF_0000_0001 → out_valid=0, out_payload=0, side_o=66'h2_DEAD_BEEF_0000_0001, bubble_cnt=1.
- **Hold:** load payload 0xA5… and then apply stall=6'b011111 for 3 cycles → out_payload stays 0xA5…, hold_cycles=3 and the state is HELD. Release stall → hold_cycles=0.
- **Flush priority:** flush=1 together with stall=6'b011111 while HELD → out_valid=0, out_payload=0, side_o=0, bubble_cnt unchanged.
- **Saturation:** with CNT_W=2, apply 5 consecutive bubbles → bubble_cnt=3 on the 3rd, 4th and 5th edge.
- **Top-stage boundary:** with STAGE=STALL_W-1 and stall[STAGE]=1 → BUBBLE every cycle (dn_stop treated as 0) and bubble_cnt increments every cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall vector encoding, per-boundary payload
// layouts (all-zero == NOP) and the decode helpers used by pipe_stage_reg.
package pipe_pkg;

    localparam int   STALL_W  = 6;
    localparam logic STOP     = 1'b1;
    localparam logic NO_STOP  = 1'b0;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int PC_W       = 32;
    localparam int INST_W     = 32;
    localparam int ALU_OP_W   = 8;
    localparam int ALU_SEL_W  = 3;

    // The NOP encoding of every field is zero, so a zeroed payload is a bubble.
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic [ALU_OP_W-1:0]   EXE_NOP_OP    = '0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } if_id_payload_t;

    typedef struct packed {
        logic [ALU_OP_W-1:0]   aluop;
        logic [ALU_SEL_W-1:0]  alusel;
        logic [DATA_W-1:0]     reg1;
        logic [DATA_W-1:0]     reg2;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [PC_W-1:0]       link_addr;
        logic                  is_in_delayslot;
    } id_ex_payload_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic                  whilo;
        logic [ALU_OP_W-1:0]   aluop;
    } ex_mem_payload_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic                  whilo;
    } mem_wb_payload_t;

    localparam int IF_ID_W  = $bits(if_id_payload_t);
    localparam int ID_EX_W  = $bits(id_ex_payload_t);
    localparam int EX_MEM_W = $bits(ex_mem_payload_t);
    localparam int MEM_WB_W = $bits(mem_wb_payload_t);

    // Only EX carries multi-cycle state ({hilo, cnt}); other boundaries tie it off.
    localparam int IF_ID_SIDE_W  = 1;
    localparam int ID_EX_SIDE_W  = 1;
    localparam int EX_MEM_SIDE_W = 2 * DATA_W + 2;
    localparam int MEM_WB_SIDE_W = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HELD  = 2'd2
    } stage_state_e;

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

    function automatic stage_act_e decode_act(input logic flush,
                                              input logic up_stop,
                                              input logic dn_stop);
        if (flush)
            return ACT_FLUSH;
        else if (up_stop == STOP && dn_stop == NO_STOP)
            return ACT_BUBBLE;
        else if (up_stop == NO_STOP)
            return ACT_ADVANCE;
        else
            return ACT_HOLD;
    endfunction

    function automatic stage_state_e state_view(input logic valid,
                                                input logic held);
        if (!valid)
            return ST_EMPTY;
        else if (held)
            return ST_HELD;
        else
            return ST_FULL;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != {CNT_W{1'b1}})
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: payload capture, bubble insertion,
// flush, loop-back side state and bubble/hold performance counters.
module pipe_stage_reg #(
    parameter int PAYLOAD_W = 128,
    parameter int SIDE_W    = 66,
    parameter int STALL_W   = pipe_pkg::STALL_W,
    parameter int STAGE     = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [SIDE_W-1:0]    side_i,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [SIDE_W-1:0]    side_o,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     hold_cycles
);

    import pipe_pkg::*;

    if (STAGE < 0 || STAGE >= STALL_W) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE out of range");
    end

    logic       up_stop;
    logic       dn_stop;
    stage_act_e act;

    assign up_stop = stall[STAGE];

    // The last stage has nothing downstream that can stall it.
    if (STAGE < STALL_W - 1) begin : g_dn
        assign dn_stop = stall[STAGE+1];
    end else begin : g_top
        assign dn_stop = NO_STOP;
    end

    // Only two bits of the global stall vector matter to any one boundary.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign act = decode_act(flush, up_stop, dn_stop);

    // NOTE: reset is synchronous and clears every register, payload included, so no X reaches downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            side_o      <= '0;
        end else begin
            unique case (act)
                ACT_FLUSH: begin
                    out_valid   <= 1'b0;
                    out_payload <= '0;
                    side_o      <= '0;
                end
                ACT_BUBBLE: begin
                    out_valid   <= 1'b0;
                    out_payload <= '0;
                    side_o      <= side_i;
                end
                ACT_ADVANCE: begin
                    out_valid   <= in_valid;
                    out_payload <= in_payload;
                    side_o      <= '0;
                end
                ACT_HOLD: begin
                    side_o      <= side_i;
                end
                default: begin
                    out_valid   <= 1'b0;
                    out_payload <= '0;
                    side_o      <= '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_BUBBLE),
        .clr   (1'b0),
        .count (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_HOLD),
        .clr   (act != ACT_HOLD),
        .count (hold_cycles)
    );

    // Running while downstream stops would overwrite a live entry: controller bug.
    a_ctrl_stall_order: assert property (@(posedge clk) disable iff (rst)
        !(up_stop == NO_STOP && dn_stop == STOP));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand-written
// saturation / top-stage sequences and a randomized run against a reference model.
module tb_pipe_stage_reg;

    import pipe_pkg::*;

    localparam int PW = 128;
    localparam int SW = 66;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_payload;
    logic [SW-1:0] side_i;

    logic          a_valid, s_valid, t_valid;
    logic [PW-1:0] a_payload, s_payload, t_payload;
    logic [SW-1:0] a_side, s_side, t_side;
    logic [15:0]   a_bub, a_hold, t_bub, t_hold;
    logic [1:0]    s_bub, s_hold;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Main instance: STAGE=3, 16-bit counters.
    pipe_stage_reg #(.PAYLOAD_W(PW), .SIDE_W(SW), .STALL_W(6), .STAGE(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_payload(in_payload), .side_i(side_i), .out_valid(a_valid),
        .out_payload(a_payload), .side_o(a_side), .bubble_cnt(a_bub), .hold_cycles(a_hold));

    // Narrow counters to reach saturation quickly.
    pipe_stage_reg #(.PAYLOAD_W(PW), .SIDE_W(SW), .STALL_W(6), .STAGE(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_payload(in_payload), .side_i(side_i), .out_valid(s_valid),
        .out_payload(s_payload), .side_o(s_side), .bubble_cnt(s_bub), .hold_cycles(s_hold));

    // Top-stage boundary: no downstream stall bit.
    pipe_stage_reg #(.PAYLOAD_W(PW), .SIDE_W(SW), .STALL_W(6), .STAGE(5), .CNT_W(16)) dut_top (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_payload(in_payload), .side_i(side_i), .out_valid(t_valid),
        .out_payload(t_payload), .side_o(t_side), .bubble_cnt(t_bub), .hold_cycles(t_hold));

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic f, input logic [5:0] st,
                         input logic v, input logic [PW-1:0] p, input logic [SW-1:0] s);
        rst = r; flush = f; stall = st; in_valid = v; in_payload = p; side_i = s;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          valid;
        logic [PW-1:0] payload;
        logic [SW-1:0] side;
        int            bub;
        int            hold;
    } model_t;

    function automatic model_t model_step(input model_t m, input int stage, input int cmax,
                                          input logic r, input logic f, input logic [5:0] st,
                                          input logic v, input logic [PW-1:0] p,
                                          input logic [SW-1:0] s);
        model_t n = m;
        bit up = ((int'(st) >> stage) % 2) == 1;
        bit dn = (stage < 5) ? (((int'(st) >> (stage + 1)) % 2) == 1) : 1'b0;
        if (r) begin
            n = '0;
        end else if (f) begin
            n.valid = 0; n.payload = '0; n.side = '0; n.hold = 0;
        end else if (up && !dn) begin
            n.valid = 0; n.payload = '0; n.side = s; n.hold = 0;
            n.bub = (m.bub < cmax) ? m.bub + 1 : cmax;
        end else if (!up) begin
            n.valid = v; n.payload = p; n.side = '0; n.hold = 0;
        end else begin
            n.side = s;
            n.hold = (m.hold < cmax) ? m.hold + 1 : cmax;
        end
        return n;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        string         name;
        logic          r;
        logic          f;
        logic [5:0]    st;
        logic          v;
        logic [PW-1:0] p;
        logic [SW-1:0] s;
        logic          ev;
        logic [PW-1:0] ep;
        logic [SW-1:0] es;
        int            eb;
        int            eh;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [PW-1:0] ones = '1;
        logic [PW-1:0] a5   = {16{8'hA5}};
        logic [SW-1:0] sb   = 66'h2_DEAD_BEEF_0000_0001;
        logic [SW-1:0] s1   = 66'h1_1111_2222_3333_4444;
        logic [SW-1:0] s2   = 66'h3_5555_6666_7777_8888;
        logic [SW-1:0] s3   = 66'h0_9999_AAAA_BBBB_CCCC;
        model_t ma, ms, mt;
        stage_state_e st_view;

        rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b1; in_payload = ones; side_i = '0;

        //          name        r  f  stall       v  payload        side  ev ep          es   eb eh
        vecs.push_back('{"rst0",   1, 0, 6'b000000, 1, ones,          s1,  0, '0,         '0,  0, 0});
        vecs.push_back('{"rst1",   1, 0, 6'b000000, 1, ones,          s1,  0, '0,         '0,  0, 0});
        vecs.push_back('{"adv",    0, 0, 6'b000000, 1, ones,          s1,  1, ones,       '0,  0, 0});
        vecs.push_back('{"bubble", 0, 0, 6'b001111, 1, ones,          sb,  0, '0,         sb,  1, 0});
        vecs.push_back('{"load",   0, 0, 6'b000000, 1, a5,            s1,  1, a5,         '0,  1, 0});
        vecs.push_back('{"hold1",  0, 0, 6'b011111, 0, '0,            s1,  1, a5,         s1,  1, 1});
        vecs.push_back('{"hold2",  0, 0, 6'b011111, 0, '0,            s2,  1, a5,         s2,  1, 2});
        vecs.push_back('{"hold3",  0, 0, 6'b011111, 0, '0,            s3,  1, a5,         s3,  1, 3});
        vecs.push_back('{"release",0, 0, 6'b000000, 1, 128'h1,        s2,  1, 128'h1,     '0,  1, 0});
        vecs.push_back('{"reheld", 0, 0, 6'b011111, 1, ones,          s2,  1, 128'h1,     s2,  1, 1});
        vecs.push_back('{"flush",  0, 1, 6'b011111, 1, ones,          s3,  0, '0,         '0,  1, 0});
        vecs.push_back('{"invcap", 0, 0, 6'b000000, 0, 128'hFACE,     s3,  0, 128'hFACE,  '0,  1, 0});
        vecs.push_back('{"dn_run", 0, 0, 6'b100000, 1, 128'h2,        s3,  1, 128'h2,     '0,  1, 0});

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].f, vecs[i].st, vecs[i].v, vecs[i].p, vecs[i].s);
            check({vecs[i].name, ".valid"},   PW'(a_valid),   PW'(vecs[i].ev));
            check({vecs[i].name, ".payload"}, a_payload,      vecs[i].ep);
            check({vecs[i].name, ".side"},    PW'(a_side),    PW'(vecs[i].es));
            check({vecs[i].name, ".bubble"},  PW'(a_bub),     PW'(vecs[i].eb));
            check({vecs[i].name, ".hold"},    PW'(a_hold),    PW'(vecs[i].eh));
            if (vecs[i].name == "hold3") begin
                st_view = state_view(a_valid, a_hold != '0);
                check("hold3.state", PW'(st_view), PW'(ST_HELD));
            end
        end

        // ---------------- saturation sequence ----------------
        apply(1, 0, 6'b000000, 0, '0, '0);
        for (int k = 1; k <= 5; k++) begin
            apply(0, 0, 6'b001111, 1, ones, s1);
            check($sformatf("sat.bub%0d", k), PW'(s_bub), PW'((k < 3) ? k : 3));
            check($sformatf("wide.bub%0d", k), PW'(a_bub), PW'(k));
        end

        // ---------------- top-stage boundary ----------------
        apply(1, 0, 6'b000000, 0, '0, '0);
        for (int k = 1; k <= 5; k++) begin
            apply(0, 0, (k <= 3) ? 6'b100000 : 6'b111111, 1, ones, s2);
            check($sformatf("top.valid%0d", k), PW'(t_valid), PW'(1'b0));
            check($sformatf("top.bub%0d", k),   PW'(t_bub),   PW'(k));
            check($sformatf("top.side%0d", k),  PW'(t_side),  PW'(s2));
        end

        // ---------------- randomized run vs model ----------------
        apply(1, 0, 6'b000000, 0, '0, '0);
        ma = '0; ms = '0; mt = '0;
        for (int c = 0; c < 400; c++) begin
            logic          r = ($urandom_range(63) == 0);
            logic          f = ($urandom_range(15) == 0);
            logic [5:0]    st = 6'($urandom);
            logic          v = 1'($urandom);
            logic [PW-1:0] p = {$urandom, $urandom, $urandom, $urandom};
            logic [SW-1:0] s = {2'($urandom), $urandom, $urandom};
            // Keep the controller legal for STAGE=3: stage 4 may only stop if stage 3 does.
            if (st[4]) st[3] = 1'b1;
            apply(r, f, st, v, p, s);
            ma = model_step(ma, 3, 65535, r, f, st, v, p, s);
            ms = model_step(ms, 3, 3,     r, f, st, v, p, s);
            mt = model_step(mt, 5, 65535, r, f, st, v, p, s);
            check($sformatf("rnd%0d.a.valid", c), PW'(a_valid), PW'(ma.valid));
            check($sformatf("rnd%0d.a.payload", c), a_payload,  ma.payload);
            check($sformatf("rnd%0d.a.side", c),  PW'(a_side),  PW'(ma.side));
            check($sformatf("rnd%0d.a.bub", c),   PW'(a_bub),   PW'(ma.bub));
            check($sformatf("rnd%0d.a.hold", c),  PW'(a_hold),  PW'(ma.hold));
            check($sformatf("rnd%0d.s.bub", c),   PW'(s_bub),   PW'(ms.bub));
            check($sformatf("rnd%0d.s.hold", c),  PW'(s_hold),  PW'(ms.hold));
            check($sformatf("rnd%0d.t.valid", c), PW'(t_valid), PW'(mt.valid));
            check($sformatf("rnd%0d.t.payload", c), t_payload,  mt.payload);
            check($sformatf("rnd%0d.t.side", c),  PW'(t_side),  PW'(mt.side));
            check($sformatf("rnd%0d.t.bub", c),   PW'(t_bub),   PW'(mt.bub));
            check($sformatf("rnd%0d.t.hold", c),  PW'(t_hold),  PW'(mt.hold));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
